// File: rtl/jtag_pkg.sv
// -----------------------------------------------------------------------------
// jtag_pkg
// Shared definitions for the JTAG TAP controller:
//   - tap_state_t : the 16 TAP states. Their encodings match the ones vendor
//                   BSCAN primitives and debuggers report, so tap_state can
//                   be compared directly against those tools.
//   - ZYNQ7_IR_LENGTH / USER4_OPCODE : default instruction register geometry.
// No ports (package).
// -----------------------------------------------------------------------------
package jtag_pkg;

    typedef enum logic [3:0] {
        TLR    = 4'hF,
        RTI    = 4'hC,
        SEL_DR = 4'h7,
        CAP_DR = 4'h6,
        SH_DR  = 4'h2,
        EX1_DR = 4'h1,
        PA_DR  = 4'h3,
        EX2_DR = 4'h0,
        UPD_DR = 4'h5,
        SEL_IR = 4'h4,
        CAP_IR = 4'hE,
        SH_IR  = 4'hA,
        EX1_IR = 4'h9,
        PA_IR  = 4'hB,
        EX2_IR = 4'h8,
        UPD_IR = 4'hD
    } tap_state_t;

    localparam int               ZYNQ7_IR_LENGTH = 10;
    localparam logic [9:0]       USER4_OPCODE    = 10'h023;

endpackage

// File: rtl/jtag_tap_fsm.sv
// -----------------------------------------------------------------------------
// jtag_tap_fsm
// The 16-state TAP state machine: next-state logic plus state register.
// Every state decode is produced as a registered output computed from the
// next state, so each strobe is a clean flop output that is high for exactly
// the cycles the FSM spends in that state.
// Ports:
//   i_tck     : TAP clock, all state changes on posedge
//   i_trst_n  : synchronous active-low reset (forces TEST_LOGIC_RESET)
//   i_tms     : test mode select
//   o_state   : current state encoding
//   o_tlr, o_rti, o_cap_dr, o_sh_dr, o_upd_dr,
//   o_cap_ir, o_sh_ir, o_upd_ir : one-hot state decodes
// -----------------------------------------------------------------------------
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       i_tck,
    input  logic       i_trst_n,
    input  logic       i_tms,
    output logic [3:0] o_state,
    output logic       o_tlr,
    output logic       o_rti,
    output logic       o_cap_dr,
    output logic       o_sh_dr,
    output logic       o_upd_dr,
    output logic       o_cap_ir,
    output logic       o_sh_ir,
    output logic       o_upd_ir
);

    tap_state_t r_state;
    tap_state_t w_next;

    logic r_tlr;
    logic r_rti;
    logic r_cap_dr;
    logic r_sh_dr;
    logic r_upd_dr;
    logic r_cap_ir;
    logic r_sh_ir;
    logic r_upd_ir;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            TLR:    w_next = i_tms ? TLR    : RTI;
            RTI:    w_next = i_tms ? SEL_DR : RTI;
            SEL_DR: w_next = i_tms ? SEL_IR : CAP_DR;
            CAP_DR: w_next = i_tms ? EX1_DR : SH_DR;
            SH_DR:  w_next = i_tms ? EX1_DR : SH_DR;
            EX1_DR: w_next = i_tms ? UPD_DR : PA_DR;
            PA_DR:  w_next = i_tms ? EX2_DR : PA_DR;
            EX2_DR: w_next = i_tms ? UPD_DR : SH_DR;
            UPD_DR: w_next = i_tms ? SEL_DR : RTI;
            SEL_IR: w_next = i_tms ? TLR    : CAP_IR;
            CAP_IR: w_next = i_tms ? EX1_IR : SH_IR;
            SH_IR:  w_next = i_tms ? EX1_IR : SH_IR;
            EX1_IR: w_next = i_tms ? UPD_IR : PA_IR;
            PA_IR:  w_next = i_tms ? EX2_IR : PA_IR;
            EX2_IR: w_next = i_tms ? UPD_IR : SH_IR;
            UPD_IR: w_next = i_tms ? SEL_DR : RTI;
            default: w_next = TLR;
        endcase
    end

    // Decodes are registered from w_next so they line up with r_state.
    always_ff @(posedge i_tck) begin
        if (!i_trst_n) begin
            r_state  <= TLR;
            r_tlr    <= 1'b1;
            r_rti    <= 1'b0;
            r_cap_dr <= 1'b0;
            r_sh_dr  <= 1'b0;
            r_upd_dr <= 1'b0;
            r_cap_ir <= 1'b0;
            r_sh_ir  <= 1'b0;
            r_upd_ir <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_tlr    <= (w_next == TLR);
            r_rti    <= (w_next == RTI);
            r_cap_dr <= (w_next == CAP_DR);
            r_sh_dr  <= (w_next == SH_DR);
            r_upd_dr <= (w_next == UPD_DR);
            r_cap_ir <= (w_next == CAP_IR);
            r_sh_ir  <= (w_next == SH_IR);
            r_upd_ir <= (w_next == UPD_IR);
        end
    end

    assign o_state  = r_state;
    assign o_tlr    = r_tlr;
    assign o_rti    = r_rti;
    assign o_cap_dr = r_cap_dr;
    assign o_sh_dr  = r_sh_dr;
    assign o_upd_dr = r_upd_dr;
    assign o_cap_ir = r_cap_ir;
    assign o_sh_ir  = r_sh_ir;
    assign o_upd_ir = r_upd_ir;

endmodule

// File: rtl/jtag_tap_ctrl.sv
// -----------------------------------------------------------------------------
// jtag_tap_ctrl
// IEEE 1149.1 TAP controller standing in for a vendor BSCAN primitive. It
// decodes TMS/TDI into the BSCAN strobes consumed by user_logic, holds the
// instruction and bypass registers, and muxes TDO.
// Ports:
//   tck              : TAP clock
//   trst_n           : synchronous active-low reset, sampled on posedge tck
//   tms, tdi         : JTAG mode select / serial data in
//   user_tdo         : serial data from user_logic (selected under USER IR)
//   tdo              : serial data out (combinational)
//   test_logic_reset, run_test_idle, capture_dr, shift_dr, update_dr :
//                      state strobes, not gated by IR
//   ir_is_user       : instruction register holds USER_OPCODE
//   tap_state        : current state encoding, debug only
// -----------------------------------------------------------------------------
module jtag_tap_ctrl
    import jtag_pkg::*;
#(
    parameter int                   IR_LENGTH   = ZYNQ7_IR_LENGTH,
    parameter logic [IR_LENGTH-1:0] USER_OPCODE = USER4_OPCODE
) (
    input  logic       tck,
    input  logic       trst_n,
    input  logic       tms,
    input  logic       tdi,
    input  logic       user_tdo,
    output logic       tdo,
    output logic       test_logic_reset,
    output logic       run_test_idle,
    output logic       capture_dr,
    output logic       shift_dr,
    output logic       update_dr,
    output logic       ir_is_user,
    output logic [3:0] tap_state
);

    // Fixed IR capture value: the 1149.1-mandated "01" in the low bits.
    localparam logic [IR_LENGTH-1:0] IR_CAPTURE = {{(IR_LENGTH-2){1'b0}}, 2'b01};

    logic                 w_tlr;
    logic                 w_rti;
    logic                 w_cap_dr;
    logic                 w_sh_dr;
    logic                 w_upd_dr;
    logic                 w_cap_ir;
    logic                 w_sh_ir;
    logic                 w_upd_ir;
    logic [3:0]           w_state;
    logic                 w_ir_is_user;

    logic [IR_LENGTH-1:0] r_ir_sr;
    logic [IR_LENGTH-1:0] r_ir_reg;
    logic                 r_bypass;

    jtag_tap_fsm u_fsm (
        .i_tck    (tck),
        .i_trst_n (trst_n),
        .i_tms    (tms),
        .o_state  (w_state),
        .o_tlr    (w_tlr),
        .o_rti    (w_rti),
        .o_cap_dr (w_cap_dr),
        .o_sh_dr  (w_sh_dr),
        .o_upd_dr (w_upd_dr),
        .o_cap_ir (w_cap_ir),
        .o_sh_ir  (w_sh_ir),
        .o_upd_ir (w_upd_ir)
    );

    assign w_ir_is_user = (r_ir_reg == USER_OPCODE);

    // The decodes are mutually exclusive, so at most one branch fires.
    always_ff @(posedge tck) begin
        if (!trst_n) begin
            r_ir_reg <= '1;
            r_ir_sr  <= '0;
            r_bypass <= 1'b0;
        end else begin
            // BYPASS is held for as long as the TAP sits in TLR.
            if (w_tlr) begin
                r_ir_reg <= '1;
            end else if (w_upd_ir) begin
                r_ir_reg <= r_ir_sr;
            end

            if (w_cap_ir) begin
                r_ir_sr <= IR_CAPTURE;
            end else if (w_sh_ir) begin
                r_ir_sr <= {tdi, r_ir_sr[IR_LENGTH-1:1]};
            end

            // Under the USER IR the DR chain belongs to user_logic, so the
            // bypass bit only shifts when the user chain is not selected.
            if (w_cap_dr) begin
                r_bypass <= 1'b0;
            end else if (w_sh_dr && !w_ir_is_user) begin
                r_bypass <= tdi;
            end
        end
    end

    always_comb begin
        tdo = 1'b0;
        if (w_sh_ir) begin
            tdo = r_ir_sr[0];
        end else if (w_sh_dr) begin
            tdo = w_ir_is_user ? user_tdo : r_bypass;
        end
    end

    assign test_logic_reset = w_tlr;
    assign run_test_idle    = w_rti;
    assign capture_dr       = w_cap_dr;
    assign shift_dr         = w_sh_dr;
    assign update_dr        = w_upd_dr;
    assign ir_is_user       = w_ir_is_user;
    assign tap_state        = w_state;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// -----------------------------------------------------------------------------
// tb_jtag_tap_ctrl
// Directed bench for jtag_tap_ctrl: reset, five-TMS escape to TLR, IR load of
// USER4, user DR scan, bypass scan, and reset in the middle of an IR shift.
// -----------------------------------------------------------------------------
module tb_jtag_tap_ctrl;

    logic       tck = 1'b0;
    logic       trst_n;
    logic       tms;
    logic       tdi;
    logic       user_tdo;
    logic       tdo;
    logic       test_logic_reset;
    logic       run_test_idle;
    logic       capture_dr;
    logic       shift_dr;
    logic       update_dr;
    logic       ir_is_user;
    logic [3:0] tap_state;

    int errors = 0;
    int checks = 0;

    always #5 tck = ~tck;

    jtag_tap_ctrl dut (
        .tck              (tck),
        .trst_n           (trst_n),
        .tms              (tms),
        .tdi              (tdi),
        .user_tdo         (user_tdo),
        .tdo              (tdo),
        .test_logic_reset (test_logic_reset),
        .run_test_idle    (run_test_idle),
        .capture_dr       (capture_dr),
        .shift_dr         (shift_dr),
        .update_dr        (update_dr),
        .ir_is_user       (ir_is_user),
        .tap_state        (tap_state)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk10(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge tck);
        #1;
    endtask

    task automatic step(input logic m, input logic d);
        tms = m;
        tdi = d;
        tick();
    endtask

    // Starts in RTI with ir_reg = BYPASS; ends in RTI with op loaded.
    task automatic load_ir(input logic [9:0] op);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk4("cap_ir_state", tap_state, 4'hE);
        step(1'b0, 1'b0);
        chk4("sh_ir_state", tap_state, 4'hA);
        for (int i = 0; i < 10; i++) begin
            tms = (i == 9);
            tdi = op[i];
            #1;
            // Captured pattern 10'h001 comes out LSB first: 1 then nine 0s.
            chk1($sformatf("ir_tdo_bit%0d", i), tdo, (i == 0));
            tick();
        end
        chk4("ex1_ir_state", tap_state, 4'h9);
        step(1'b1, 1'b0);
        chk4("upd_ir_state", tap_state, 4'hD);
        chk1("ir_is_user_in_upd_ir", ir_is_user, 1'b0);
        step(1'b0, 1'b0);
        chk4("rti_after_upd_ir", tap_state, 4'hC);
        chk1("ir_is_user_after_upd", ir_is_user, 1'b1);
        chk10("ir_reg_loaded", dut.r_ir_reg, op);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] esc_exp [5];
        logic [3:0] byp_tdi;
        logic [3:0] byp_exp;
        int         n_cap;
        int         n_sh;
        int         n_upd;

        esc_exp = '{4'h1, 4'h5, 4'h7, 4'h4, 4'hF};
        byp_tdi = 4'b1101;   // tdi 1,0,1,1 in time order (bit 0 first)
        byp_exp = 4'b1010;   // tdo 0,1,0,1 in time order

        trst_n   = 1'b0;
        tms      = 1'b0;
        tdi      = 1'b0;
        user_tdo = 1'b0;

        // Reset for 3 edges, then release.
        repeat (3) tick();
        trst_n = 1'b1;
        #1;
        chk4("rst_state", tap_state, 4'hF);
        chk1("rst_tlr", test_logic_reset, 1'b1);
        chk1("rst_rti", run_test_idle, 1'b0);
        chk1("rst_cap_dr", capture_dr, 1'b0);
        chk1("rst_sh_dr", shift_dr, 1'b0);
        chk1("rst_upd_dr", update_dr, 1'b0);
        chk1("rst_ir_is_user", ir_is_user, 1'b0);
        chk1("rst_tdo", tdo, 1'b0);
        chk10("rst_ir_reg", dut.r_ir_reg, 10'h3FF);

        step(1'b0, 1'b0);
        chk4("rti_state", tap_state, 4'hC);
        chk1("rti_strobe", run_test_idle, 1'b1);
        chk1("rti_tlr_low", test_logic_reset, 1'b0);

        // Into SHIFT_DR, then escape with five tms=1.
        step(1'b1, 1'b0);
        chk4("sel_dr_state", tap_state, 4'h7);
        step(1'b0, 1'b0);
        chk4("cap_dr_state", tap_state, 4'h6);
        step(1'b0, 1'b0);
        chk4("sh_dr_state", tap_state, 4'h2);
        chk1("sh_dr_strobe", shift_dr, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0);
            chk4($sformatf("escape_edge%0d", i + 1), tap_state, esc_exp[i]);
        end
        chk1("escape_tlr", test_logic_reset, 1'b1);
        chk10("escape_ir_reg", dut.r_ir_reg, 10'h3FF);
        chk1("escape_ir_is_user", ir_is_user, 1'b0);

        // Load USER4.
        step(1'b0, 1'b0);
        chk4("rti_before_ir", tap_state, 4'hC);
        load_ir(10'h023);

        // 8-bit user DR scan with user_tdo driven from a counter.
        n_cap = 0;
        n_sh  = 0;
        n_upd = 0;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk4("user_cap_dr_state", tap_state, 4'h6);
        for (int c = 0; c < 11; c++) begin
            logic [3:0] cnt;
            cnt      = 4'(c + 5);
            user_tdo = cnt[1];
            tdi      = cnt[0];
            tms      = (c == 8) || (c == 9);
            #1;
            if (capture_dr) n_cap++;
            if (update_dr)  n_upd++;
            if (shift_dr) begin
                n_sh++;
                chk1($sformatf("user_tdo_cycle%0d", c), tdo, cnt[1]);
            end
            tick();
        end
        chk4("user_scan_end_state", tap_state, 4'hC);
        checks++;
        assert (n_cap == 1 && n_sh == 8 && n_upd == 1) else begin
            errors++;
            $error("FAIL user_strobe_counts observed=%0d/%0d/%0d expected=1/8/1",
                   n_cap, n_sh, n_upd);
        end
        user_tdo = 1'b0;

        // Back to BYPASS through TLR, then a 4-bit bypass scan.
        repeat (5) step(1'b1, 1'b0);
        chk4("tlr_again", tap_state, 4'hF);
        step(1'b0, 1'b0);
        chk1("bypass_ir_is_user", ir_is_user, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk4("byp_sh_dr_state", tap_state, 4'h2);
        for (int i = 0; i < 4; i++) begin
            tms = (i == 3);
            tdi = byp_tdi[i];
            user_tdo = ~byp_exp[i];
            #1;
            chk1($sformatf("bypass_tdo%0d", i), tdo, byp_exp[i]);
            tick();
        end
        user_tdo = 1'b0;
        chk4("byp_ex1_dr_state", tap_state, 4'h1);
        step(1'b1, 1'b0);
        chk1("byp_upd_dr", update_dr, 1'b1);
        step(1'b0, 1'b0);
        chk4("byp_rti", tap_state, 4'hC);

        // Reset in the middle of an IR shift.
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk4("mid_sh_ir_state", tap_state, 4'hA);
        repeat (4) step(1'b0, 1'b1);
        chk4("mid_still_sh_ir", tap_state, 4'hA);
        trst_n = 1'b0;
        step(1'b0, 1'b0);
        trst_n = 1'b1;
        #1;
        chk4("mid_rst_state", tap_state, 4'hF);
        chk10("mid_rst_ir_reg", dut.r_ir_reg, 10'h3FF);
        chk10("mid_rst_ir_sr", dut.r_ir_sr, 10'h000);
        chk1("mid_rst_tdo", tdo, 1'b0);
        step(1'b0, 1'b0);
        load_ir(10'h023);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/jtag_tap_ctrl.md
Name: jtag_tap_ctrl

Overview:
- IEEE 1149.1 TAP controller: the TAP/BSCAN end of the interface consumed by user_logic.
- Decodes TMS/TDI on tck into the BSCAN strobes (test_logic_reset, capture_dr, shift_dr, update_dr, ir_is_user).
- Holds the instruction register and the bypass register, and muxes TDO.
- Used in simulation benches and FPGA-less builds in place of the vendor BSCAN primitive, directly wired to user_logic.

Parameters:
- IR_LENGTH, 10: instruction register width in bits.
- USER_OPCODE, 10'h023: IR value that selects the user chain (USER4); drives ir_is_user.

Ports:
- tck  in  1  TAP clock; all state changes on posedge.
- trst_n  in  1  synchronous active-low reset, sampled on posedge tck.
- tms  in  1  test mode select.
- tdi  in  1  serial data in.
- user_tdo  in  1  serial data returned by user_logic.
- tdo  out  1  serial data out (combinational mux).
- test_logic_reset  out  1  state == TEST_LOGIC_RESET.
- run_test_idle  out  1  state == RUN_TEST_IDLE.
- capture_dr  out  1  state == CAPTURE_DR.
- shift_dr  out  1  state == SHIFT_DR.
- update_dr  out  1  state == UPDATE_DR.
- ir_is_user  out  1  ir_reg == USER_OPCODE.
- tap_state  out  4  current state encoding, for debug.

Behaviour:
- 16-state TAP FSM, standard 1149.1 transitions on tms each posedge tck:
  - TLR: tms=1 stays, tms=0 -> RTI.
  - RTI: tms=1 -> SELECT_DR; tms=0 stays.
  - SELECT_DR: tms=0 -> CAPTURE_DR; tms=1 -> SELECT_IR.
  - SELECT_IR: tms=0 -> CAPTURE_IR; tms=1 -> TLR.
  - CAPTURE_x: tms=0 -> SHIFT_x; tms=1 -> EXIT1_x.
  - SHIFT_x: tms=1 -> EXIT1_x; tms=0 stays.
  - EXIT1_x: tms=0 -> PAUSE_x; tms=1 -> UPDATE_x.
  - PAUSE_x: tms=1 -> EXIT2_x; tms=0 stays.
  - EXIT2_x: tms=0 -> SHIFT_x; tms=1 -> UPDATE_x.
  - UPDATE_x: tms=1 -> SELECT_DR; tms=0 -> RTI.
- Five consecutive tms=1 cycles reach TLR from any state.
- Strobe outputs are Moore-decoded from the state register: no glitches, valid for the whole cycle spent in that state. Strobes are not gated by IR; consumers gate with ir_is_user.
- IR shift register ir_sr[IR_LENGTH-1:0]:
  - CAPTURE_IR loads {zeros, 2'b01}.
  - SHIFT_IR shifts right with tdi into the MSB.
  - UPDATE_IR copies ir_sr into ir_reg.
- ir_reg:
  - Set to all-ones (BYPASS) whenever state is TLR, including the cycle after reset.
  - Otherwise changes only in UPDATE_IR.
- Bypass register, 1 bit: CAPTURE_DR (any IR) loads 0; SHIFT_DR with ir_is_user=0 loads tdi.
- tdo, combinational:
  - SHIFT_IR -> ir_sr[0].
  - SHIFT_DR and ir_is_user -> user_tdo.
  - SHIFT_DR and not ir_is_user -> bypass bit.
  - Otherwise 0.
- Reset, trst_n=0 on posedge:
  - state=TLR, ir_reg=all-ones, ir_sr=0, bypass=0.
  - Takes priority over tms; a reset mid-shift drops the partial shift.
- Outputs in the first cycle after reset:
  - test_logic_reset=1, all other strobes 0, ir_is_user=0 (unless USER_OPCODE is all-ones).
  - tap_state=4'hF, tdo=0.
- Latency: strobes follow tms with one tck; ir_is_user is valid in the cycle after UPDATE_IR.

Decomposition:
- Package jtag_pkg:
  - tap_state_t enum with IEEE encodings: TLR=F, RTI=C, SEL_DR=7, CAP_DR=6, SH_DR=2, EX1_DR=1, PA_DR=3, EX2_DR=0, UPD_DR=5, SEL_IR=4, CAP_IR=E, SH_IR=A, EX1_IR=9, PA_IR=B, EX2_IR=8, UPD_IR=D.
  - ZYNQ7_IR_LENGTH=10 and USER4_OPCODE constants.
- One sub-module, jtag_tap_fsm: the pure next-state logic plus state register.
- IR, bypass and tdo mux stay in the top module.

Test Plan:
- trst_n=0 for 3 cycles, then tms=0 -> cycle after release: tap_state=F, test_logic_reset=1; next cycle: run_test_idle=1, tap_state=C.
- From SHIFT_DR, tms=1 x5 -> tap_state=F after exactly 5 edges; ir_reg=3FF, ir_is_user=0.
- Path RTI->SEL_DR->SEL_IR->CAP_IR->SHIFT_IR, shift 10'h023 LSB-first, exit, update:
  - tdo during the shift shows the capture pattern 1,0,0,0,0,0,0,0,0,0.
  - ir_is_user=1 from the cycle after UPD_IR.
- With USER IR, DR scan of 8 bits with user_tdo tied to a counter:
  - capture_dr high exactly 1 cycle, shift_dr high 8 cycles, update_dr high 1 cycle.
  - tdo mirrors user_tdo.
- With BYPASS IR, shift tdi pattern 1,0,1,1 -> tdo=0,1,0,1 (one-cycle delay, leading captured 0).
- trst_n=0 asserted during SHIFT_IR after 4 bits -> state F next cycle, ir_reg=3FF; a subsequent full USER4 load still succeeds.
